// File: rtl/mw_stage_if.sv
// M->W pipeline boundary: M-stage results and pipeline control in, W-stage write-back info out.
interface mw_stage_if;
    logic        Stall;
    logic        Flush;
    logic [31:0] M_PC;
    logic [4:0]  M_RegAddr;
    logic        M_RegWE;
    logic [31:0] M_ALUOut;
    logic [31:0] M_DMRead;
    logic [2:0]  M_LoadType;
    logic [1:0]  M_WDSel;
    logic [1:0]  M_Tnew;
    logic [31:0] W_PC;
    logic [4:0]  W_RegAddr;
    logic        W_RegWE;
    logic [31:0] W_WD;
    logic [1:0]  W_Tnew;
    logic        W_Valid;

    modport master (
        output Stall, Flush, M_PC, M_RegAddr, M_RegWE, M_ALUOut, M_DMRead,
               M_LoadType, M_WDSel, M_Tnew,
        input  W_PC, W_RegAddr, W_RegWE, W_WD, W_Tnew, W_Valid
    );

    modport slave (
        input  Stall, Flush, M_PC, M_RegAddr, M_RegWE, M_ALUOut, M_DMRead,
               M_LoadType, M_WDSel, M_Tnew,
        output W_PC, W_RegAddr, W_RegWE, W_WD, W_Tnew, W_Valid
    );
endinterface

// File: rtl/mw_stage_reg.sv
// M->W pipeline register: latches M-stage results, then extracts/extends the loaded
// data and selects the GRF write-back value combinationally in W.
module mw_stage_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        Clk,
    input  logic        Reset,
    mw_stage_if.slave   bus
);

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_t;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_DM  = 2'd1,
        WD_PC8 = 2'd2,
        WD_RSV = 2'd3
    } wdsel_t;

    logic [31:0] pc_q;
    logic [4:0]  regaddr_q;
    logic        regwe_q;
    logic [31:0] aluout_q;
    logic [31:0] dmread_q;
    logic [31:0] pc8_q;
    logic [2:0]  loadtype_q;
    logic [1:0]  wdsel_q;
    logic [1:0]  tnew_q;
    logic        valid_q;

    always_ff @(posedge Clk) begin
        if (Reset || bus.Flush) begin
            pc_q       <= RESET_PC;
            regaddr_q  <= '0;
            regwe_q    <= 1'b0;
            aluout_q   <= '0;
            dmread_q   <= '0;
            pc8_q      <= '0;
            loadtype_q <= '0;
            wdsel_q    <= '0;
            tnew_q     <= '0;
            valid_q    <= 1'b0;
        end else if (!bus.Stall) begin
            pc_q       <= bus.M_PC;
            regaddr_q  <= bus.M_RegAddr;
            regwe_q    <= bus.M_RegWE;
            aluout_q   <= bus.M_ALUOut;
            dmread_q   <= bus.M_DMRead;
            pc8_q      <= bus.M_PC + 32'd8;
            loadtype_q <= bus.M_LoadType;
            wdsel_q    <= bus.M_WDSel;
            // Tnew counts down toward zero but must not wrap back to 3.
            tnew_q     <= (bus.M_Tnew == 2'd0) ? 2'd0 : bus.M_Tnew - 2'd1;
            valid_q    <= 1'b1;
        end
    end

    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        off     = aluout_q[1:0];
        ld_byte = dmread_q[8*off +: 8];
        ld_half = off[1] ? dmread_q[31:16] : dmread_q[15:0];
        ld_ext  = dmread_q;
        case (load_t'(loadtype_q))
            LT_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            LT_LBU:  ld_ext = {24'd0, ld_byte};
            LT_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            LT_LHU:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dmread_q;
        endcase
    end

    logic [31:0] wd;

    always_comb begin
        wd = aluout_q;
        case (wdsel_t'(wdsel_q))
            WD_DM:   wd = ld_ext;
            WD_PC8:  wd = pc8_q;
            default: wd = aluout_q;
        endcase
    end

    assign bus.W_PC      = pc_q;
    assign bus.W_RegAddr = regaddr_q;
    assign bus.W_RegWE   = regwe_q & (regaddr_q != 5'd0) & valid_q;
    assign bus.W_WD      = wd;
    assign bus.W_Tnew    = tnew_q;
    assign bus.W_Valid   = valid_q;

endmodule

// File: tb/tb_mw_stage_reg.sv
// Scoreboarded random/directed bench for mw_stage_reg against a behavioural W-stage model.
module tb_mw_stage_reg;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    mw_stage_if mw ();

    mw_stage_reg #(.RESET_PC(32'h0000_3000)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (mw)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic        we;
        logic [31:0] wd;
        logic [1:0]  tnew;
        logic        valid;
    } wstate_t;

    typedef struct {
        int          edge_no;
        wstate_t     exp;
        bit          spot;
        wstate_t     spot_val;
    } sb_item_t;

    sb_item_t sbq[$];
    wstate_t  model;
    int       edge_cnt = 0;
    int       checks = 0;
    int       failures = 0;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_ext(input logic [31:0] dm, input logic [31:0] addr,
                                             input logic [2:0] lt);
        int unsigned o;
        logic [31:0] b;
        logic [31:0] h;
        o = addr % 4;
        b = (dm >> (8 * o)) & 32'hFF;
        h = (o >= 2) ? (dm >> 16) : (dm & 32'hFFFF);
        case (lt)
            3'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return dm;
        endcase
    endfunction

    // Drive one cycle of M-stage inputs and record the W state expected after the next edge.
    task automatic step(input bit rst, input bit fl, input bit st,
                        input logic [31:0] pc, input logic [4:0] addr, input bit we,
                        input logic [31:0] alu, input logic [31:0] dm, input logic [2:0] lt,
                        input logic [1:0] wds, input logic [1:0] tn,
                        input bit spot = 0, input wstate_t spot_val = '{default: '0});
        sb_item_t it;
        @(posedge Clk);
        #1;
        Reset         = rst;
        mw.Flush      = fl;
        mw.Stall      = st;
        mw.M_PC       = pc;
        mw.M_RegAddr  = addr;
        mw.M_RegWE    = we;
        mw.M_ALUOut   = alu;
        mw.M_DMRead   = dm;
        mw.M_LoadType = lt;
        mw.M_WDSel    = wds;
        mw.M_Tnew     = tn;
        if (rst || fl) begin
            model = '{pc: 32'h0000_3000, addr: 5'd0, we: 1'b0, wd: 32'd0, tnew: 2'd0, valid: 1'b0};
        end else if (!st) begin
            model.pc    = pc;
            model.addr  = addr;
            model.we    = we && (addr != 0);
            model.wd    = (wds == 2'd1) ? load_ext(dm, alu, lt) :
                          (wds == 2'd2) ? pc + 32'd8 : alu;
            model.tnew  = (tn == 0) ? 2'd0 : tn - 2'd1;
            model.valid = 1'b1;
        end
        it.edge_no  = edge_cnt + 1;
        it.exp      = model;
        it.spot     = spot;
        it.spot_val = spot_val;
        sbq.push_back(it);
    endtask

    // Monitor: after each edge, compare the W outputs to whatever was predicted for that edge.
    initial begin
        sb_item_t it;
        forever begin
            @(negedge Clk);
            while (sbq.size() > 0 && sbq[0].edge_no <= edge_cnt) begin
                it = sbq.pop_front();
                chk32("W_PC",      mw.W_PC,              it.exp.pc);
                chk32("W_RegAddr", {27'd0, mw.W_RegAddr}, {27'd0, it.exp.addr});
                chk32("W_RegWE",   {31'd0, mw.W_RegWE},   {31'd0, it.exp.we});
                chk32("W_WD",      mw.W_WD,              it.exp.wd);
                chk32("W_Tnew",    {30'd0, mw.W_Tnew},    {30'd0, it.exp.tnew});
                chk32("W_Valid",   {31'd0, mw.W_Valid},   {31'd0, it.exp.valid});
                if (it.spot) begin
                    chk32("spot_W_PC",    mw.W_PC,            it.spot_val.pc);
                    chk32("spot_W_RegWE", {31'd0, mw.W_RegWE}, {31'd0, it.spot_val.we});
                    chk32("spot_W_WD",    mw.W_WD,            it.spot_val.wd);
                    chk32("spot_W_Tnew",  {30'd0, mw.W_Tnew},  {30'd0, it.spot_val.tnew});
                    chk32("spot_W_Valid", {31'd0, mw.W_Valid}, {31'd0, it.spot_val.valid});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic wstate_t sv(input logic [31:0] pc, input logic we, input logic [31:0] wd,
                                   input logic [1:0] tn, input logic v);
        sv = '{pc: pc, addr: 5'd0, we: we, wd: wd, tnew: tn, valid: v};
    endfunction

    initial begin
        Reset = 1'b1;
        mw.Flush = 0; mw.Stall = 0; mw.M_PC = 0; mw.M_RegAddr = 0; mw.M_RegWE = 0;
        mw.M_ALUOut = 0; mw.M_DMRead = 0; mw.M_LoadType = 0; mw.M_WDSel = 0; mw.M_Tnew = 0;

        // Reset for two cycles
        step(1, 0, 0, 32'h1234, 5'd7, 1, 32'h55, 32'h66, 3'd0, 2'd0, 2'd2);
        step(1, 0, 0, 32'h1234, 5'd7, 1, 32'h55, 32'h66, 3'd0, 2'd0, 2'd2,
             1, sv(32'h3000, 0, 32'h0, 2'd0, 0));

        // Byte and half loads
        step(0, 0, 0, 32'h3000, 5'd8, 1, 32'h0000_1001, 32'h1280_F37A, 3'd1, 2'd1, 2'd1,
             1, sv(32'h3000, 1, 32'hFFFF_FFF3, 2'd0, 1));
        step(0, 0, 0, 32'h3004, 5'd8, 1, 32'h0000_1001, 32'h1280_F37A, 3'd2, 2'd1, 2'd1,
             1, sv(32'h3004, 1, 32'h0000_00F3, 2'd0, 1));
        step(0, 0, 0, 32'h3008, 5'd9, 1, 32'h0000_2002, 32'h8001_7FFF, 3'd3, 2'd1, 2'd1,
             1, sv(32'h3008, 1, 32'hFFFF_8001, 2'd0, 1));
        step(0, 0, 0, 32'h300C, 5'd9, 1, 32'h0000_2002, 32'h8001_7FFF, 3'd4, 2'd1, 2'd1,
             1, sv(32'h300C, 1, 32'h0000_8001, 2'd0, 1));
        step(0, 0, 0, 32'h3010, 5'd9, 1, 32'h0000_2000, 32'h8001_7FFF, 3'd3, 2'd1, 2'd1,
             1, sv(32'h3010, 1, 32'h0000_7FFF, 2'd0, 1));

        // jal link value and Tnew countdown
        step(0, 0, 0, 32'h3010, 5'd31, 1, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd2, 2'd0,
             1, sv(32'h3010, 1, 32'h0000_3018, 2'd0, 1));
        step(0, 0, 0, 32'h3014, 5'd31, 1, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd2, 2'd2,
             1, sv(32'h3014, 1, 32'h0000_301C, 2'd1, 1));

        // Write to $0 suppressed, then stall with moving inputs, then flush during stall
        step(0, 0, 0, 32'h3020, 5'd0, 1, 32'h0000_0042, 32'h0, 3'd0, 2'd0, 2'd1,
             1, sv(32'h3020, 0, 32'h0000_0042, 2'd0, 1));
        for (int unsigned i = 0; i < 3; i++)
            step(0, 0, 1, 32'h4000 + i, 5'd3 + 5'(i), 1, $urandom, $urandom, 3'(i), 2'(i), 2'd3,
                 1, sv(32'h3020, 0, 32'h0000_0042, 2'd0, 1));
        step(0, 1, 1, 32'h5000, 5'd4, 1, 32'h77, 32'h88, 3'd0, 2'd0, 2'd1,
             1, sv(32'h3000, 0, 32'h0, 2'd0, 0));

        // Reset while stalled
        step(0, 0, 0, 32'h6000, 5'd5, 1, 32'h99, 32'h0, 3'd0, 2'd0, 2'd3);
        step(1, 0, 1, 32'h6004, 5'd6, 1, 32'hAA, 32'h0, 3'd0, 2'd0, 2'd3,
             1, sv(32'h3000, 0, 32'h0, 2'd0, 0));

        // Randomised traffic, including PC+8 wraparound and reserved selects
        for (int unsigned i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk32("scoreboard_drained", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
